pdp8_uart: RTL

- Byte-serial UART core directly downstream of the PDP-8 console TT device (TTO/TTI), replacing the generic uart instance.
- Accepts a byte over a level req/ack handshake and shifts it out as 8N1.
- Samples the serial input at 16x oversample and offers each received byte over a matching req/ack handshake.
- Baud ticks arrive from the baud-rate generator as single-cycle enables synchronous to clk.

---
 rtl/pdp8_uart_pkg.sv | 25 ++
 rtl/pdp8_uart_rx.sv | 161 ++++++++++++++++
 rtl/pdp8_uart.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pdp8_uart_pkg.sv
// Shared definitions for the PDP-8 console UART: state encodings, line levels
// and the default oversampling ratio.
package pdp8_uart_pkg;

    localparam int   DEFAULT_OVERSAMPLE = 16;
    localparam logic START_BIT          = 1'b0;
    localparam logic STOP_BIT           = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_WAIT  = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rxState_t;

endpackage

// File: rtl/pdp8_uart_rx.sv
// UART receiver: input synchronizer, oversampling frame FSM, one-byte holding
// register and the req/ack handshake that hands the byte to the TTI side.
module pdp8_uart_rx
    import pdp8_uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_clk,
    input  logic                 rx_req,
    input  logic                 rx_in,
    output logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 r_sync1, r_sync2;
    logic                 w_line;
    rxState_t             r_state, w_stateNext;
    logic [CW-1:0]        r_cnt, w_cntNext;
    logic [BW-1:0]        r_bitCnt, w_bitCntNext;
    logic [DATA_BITS-1:0] r_shift, w_shiftNext;
    logic [DATA_BITS-1:0] r_data, w_dataNext;
    logic                 r_empty, w_emptyNext;
    logic                 r_ack, w_ackNext;
    logic                 r_frameErr, w_frameErrNext;
    logic                 r_overrun, w_overrunNext;

    assign w_line = r_sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_empty    <= 1'b1;
            r_ack      <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync1    <= rx_in;
            r_sync2    <= r_sync1;
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_bitCnt   <= w_bitCntNext;
            r_shift    <= w_shiftNext;
            r_data     <= w_dataNext;
            r_empty    <= w_emptyNext;
            r_ack      <= w_ackNext;
            r_frameErr <= w_frameErrNext;
            r_overrun  <= w_overrunNext;
        end
    end

    // Delivery needs an empty holder and ack release needs a full one, so
    // the two never compete for w_emptyNext on the same edge.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_bitCntNext   = r_bitCnt;
        w_shiftNext    = r_shift;
        w_dataNext     = r_data;
        w_emptyNext    = r_empty;
        w_ackNext      = r_ack;
        w_frameErrNext = 1'b0;
        w_overrunNext  = 1'b0;

        if (rx_req && !r_empty && !r_ack) begin
            w_ackNext = 1'b1;
        end else if (r_ack && !rx_req) begin
            w_ackNext   = 1'b0;
            w_emptyNext = 1'b1;
        end

        unique case (r_state)
            RX_IDLE: begin
                if (rx_clk && w_line == START_BIT) begin
                    w_cntNext   = '0;
                    w_stateNext = RX_START;
                end
            end
            RX_START: begin
                if (rx_clk) begin
                    if (r_cnt == HALF_M1) begin
                        w_cntNext = '0;
                        if (w_line == START_BIT) begin
                            w_bitCntNext = '0;
                            w_stateNext  = RX_DATA;
                        end else begin
                            w_stateNext = RX_IDLE;
                        end
                    end else begin
                        w_cntNext = r_cnt + CW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (rx_clk) begin
                    if (r_cnt == FULL_M1) begin
                        w_cntNext    = '0;
                        w_shiftNext  = {w_line, r_shift[DATA_BITS-1:1]};
                        w_bitCntNext = r_bitCnt + BW'(1);
                        if (r_bitCnt == LAST_BIT) begin
                            w_stateNext = RX_STOP;
                        end
                    end else begin
                        w_cntNext = r_cnt + CW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_clk) begin
                    if (r_cnt == FULL_M1) begin
                        w_cntNext = '0;
                        if (w_line == STOP_BIT) begin
                            w_stateNext = RX_IDLE;
                            if (r_empty) begin
                                w_dataNext  = r_shift;
                                w_emptyNext = 1'b0;
                            end else begin
                                w_overrunNext = 1'b1;
                            end
                        end else begin
                            w_frameErrNext = 1'b1;
                            w_stateNext    = RX_BREAK;
                        end
                    end else begin
                        w_cntNext = r_cnt + CW'(1);
                    end
                end
            end
            RX_BREAK: begin
                if (rx_clk && w_line == STOP_BIT) begin
                    w_stateNext = RX_IDLE;
                end
            end
            default: w_stateNext = RX_IDLE;
        endcase
    end

    assign rx_ack       = r_ack;
    assign rx_data      = r_data;
    assign rx_empty     = r_empty;
    assign rx_frame_err = r_frameErr;
    assign rx_overrun   = r_overrun;

endmodule

// File: rtl/pdp8_uart.sv
// PDP-8 console UART: 8N1 transmitter driven by a 1x bit tick, plus the
// oversampling receiver sub-module, each behind a level req/ack handshake.
module pdp8_uart
    import pdp8_uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_clk,
    input  logic                 tx_req,
    output logic                 tx_ack,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_empty,
    input  logic                 rx_clk,
    input  logic                 rx_req,
    output logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    input  logic                 rx_in,
    output logic                 tx_out,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int BW = $clog2(DATA_BITS + 1);

    txState_t             r_txState, w_txStateNext;
    logic                 r_txAck, w_txAckNext;
    logic                 r_txEmpty, w_txEmptyNext;
    logic                 r_txOut, w_txOutNext;
    logic [DATA_BITS-1:0] r_txShift, w_txShiftNext;
    logic [BW-1:0]        r_txBitCnt, w_txBitCntNext;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_txState  <= TX_IDLE;
            r_txAck    <= 1'b0;
            r_txEmpty  <= 1'b1;
            r_txOut    <= STOP_BIT;
            r_txShift  <= '0;
            r_txBitCnt <= '0;
        end else begin
            r_txState  <= w_txStateNext;
            r_txAck    <= w_txAckNext;
            r_txEmpty  <= w_txEmptyNext;
            r_txOut    <= w_txOutNext;
            r_txShift  <= w_txShiftNext;
            r_txBitCnt <= w_txBitCntNext;
        end
    end

    // The ack release runs independently of shifting; a byte is only accepted
    // from IDLE with ack low, so a held request can never trigger a resend.
    always_comb begin
        w_txStateNext  = r_txState;
        w_txAckNext    = r_txAck;
        w_txEmptyNext  = r_txEmpty;
        w_txOutNext    = r_txOut;
        w_txShiftNext  = r_txShift;
        w_txBitCntNext = r_txBitCnt;

        if (r_txAck && !tx_req) begin
            w_txAckNext = 1'b0;
        end
        if (r_txState == TX_IDLE && !r_txAck) begin
            w_txEmptyNext = 1'b1;
        end

        unique case (r_txState)
            TX_IDLE: begin
                if (tx_req && !r_txAck) begin
                    w_txShiftNext = tx_data;
                    w_txAckNext   = 1'b1;
                    w_txEmptyNext = 1'b0;
                    w_txStateNext = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_clk) begin
                    w_txOutNext   = START_BIT;
                    w_txStateNext = TX_START;
                end
            end
            TX_START: begin
                if (tx_clk) begin
                    w_txOutNext    = r_txShift[0];
                    w_txShiftNext  = r_txShift >> 1;
                    w_txBitCntNext = BW'(1);
                    w_txStateNext  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_clk) begin
                    if (r_txBitCnt == BW'(DATA_BITS)) begin
                        w_txOutNext   = STOP_BIT;
                        w_txStateNext = TX_STOP;
                    end else begin
                        w_txOutNext    = r_txShift[0];
                        w_txShiftNext  = r_txShift >> 1;
                        w_txBitCntNext = r_txBitCnt + BW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tx_clk) begin
                    w_txStateNext = TX_IDLE;
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
    end

    assign tx_ack   = r_txAck;
    assign tx_empty = r_txEmpty;
    assign tx_out   = r_txOut;

    pdp8_uart_rx #(
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_clk       (rx_clk),
        .rx_req       (rx_req),
        .rx_in        (rx_in),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

endmodule
